quad_speed_meter: RTL and testbench
===================================

// Module: quad_speed_meter
// PURPOSE
//  Quadrature decoder and speed meter for one wheel encoder. Its signed position and windowed
//  speed words feed the SPI slave's MISO register file, which the Pi reads over SPI.
//  Instantiate one per wheel (FL, RL, FR, RR); speed[15:0] packs into the 32-bit SPI words.
// PARAMETERS
//  WINDOW_CYCLES  500000  speed sample window in clk cycles (10 ms @ 50 MHz); >= 2
//  FILT_LEN       4       consecutive stable cycles required to accept an A/B level change; >= 1
//  DIR_INVERT     0       1 = negate count direction (mirrored wheels)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   asynchronous active-low reset
//  enc_a        in   1   encoder channel A, asynchronous pin
//  enc_b        in   1   encoder channel B, asynchronous pin
//  clear        in   1   sync pulse: zero position, error, accumulator; restart window
//  position     out  32  signed 4x-decoded count, wraps two's complement
//  speed        out  32  signed counts in last completed window
//  speed_valid  out  1   one-cycle strobe when speed updates
//  enc_err      out  1   sticky: illegal A/B transition seen (both bits changed)
// BEHAVIOUR
//  Reset: all outputs 0; sync/filter regs 00; window counter 0; init flag set.
//  Input path: 2-FF synchroniser on enc_a and enc_b, then a per-channel filter counter.
//   - The filtered bit takes the synced value after it differs from the filtered bit for
//     FILT_LEN consecutive cycles.
//   - Any cycle where synced equals filtered resets that channel's counter.
//  Decode: prev/cur registered pair {A,B}.
//   - Forward (+1): 00->01->11->10->00. Reverse (-1): opposite order.
//   - Both bits changed: no count, enc_err <= 1.
//   - DIR_INVERT swaps the sign.
//  Init: while the init flag is set, the first filter acceptance only loads prev and does
//   not count; the flag then clears. No spurious step or error occurs after reset with a
//   pin already high.
//  Latency: a clean pin edge, held stable, changes position exactly FILT_LEN+3 clk edges
//   after the first clk edge that samples the new level.
//  Window: counter runs 0..WINDOW_CYCLES-1. The signed 32-bit accumulator adds every step
//   and saturates at +/-(2^31-1); no wrap.
//   - On the terminal count cycle: speed <= acc + step_of_this_cycle, acc <= 0,
//     counter <= 0, speed_valid = 1 on the following cycle for exactly one cycle.
//   - speed holds its value between strobes.
//  clear:
//   - Next cycle: position = 0, enc_err = 0, acc = 0, window counter = 0.
//   - speed is untouched.
//   - clear on a terminal-count cycle wins: no speed update, no strobe.
//   - A step decoded in the same cycle as clear is discarded.
//  Reset mid-window or mid-filter: everything returns to reset state; init flag set again.
//  The FSM is implicit in the filter counters plus init flag: INIT -> RUN on the first
//   acceptance; RUN -> INIT only on reset.
// TESTING
//  1. Reset with A=B=0; 8 forward quadrature cycles (32 edges, each level held 10 clk)
//     -> position = 32, enc_err = 0.
//  2. Same pattern reversed with DIR_INVERT=0 -> position = -32. With DIR_INVERT=1 -> +32.
//  3. WINDOW_CYCLES=1000, 50 forward edges spaced 15 clk -> after the first strobe
//     speed = 50; the next window with no motion -> speed = 0. Strobes exactly 1000 clk apart.
//  4. Glitches of FILT_LEN-1 cycles on A with FILT_LEN=4 -> position unchanged.
//     A 4-cycle pulse -> accepted. Latency checked = 7 clk.
//  5. Force A and B to toggle in the same cycle from 00 to 11 -> enc_err = 1, position unchanged.
//     Pulse clear -> enc_err = 0, position = 0.
//  6. Assert clear on the terminal-count cycle -> no speed_valid, speed keeps the old value.
//     Assert reset_n low mid-window -> all outputs 0 immediately (async). Release with A=1
//     -> position stays 0.

Source files
------------

// File: rtl/quad_speed_meter.sv
// quad_speed_meter
//   Quadrature decoder and windowed speed meter for one wheel encoder.
//   A/B pins are synchronised, glitch-filtered, 4x decoded into a signed
//   position, and the signed step count of each window is published as speed.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enc_a/enc_b  raw encoder channels (asynchronous pins)
//   clear        sync pulse: zero position, error, accumulator; restart window
//   position     signed 32-bit 4x count, wraps two's complement
//   speed        signed step count of the last completed window
//   speed_valid  one-cycle strobe when speed updates
//   enc_err      sticky flag: both A and B changed in one step
//
// state   | meaning
// --------+-------------------------------------------------------------------
// ST_INIT | filtered levels and prev follow the synchronised pins, no counting
// ST_RUN  | filter acceptances are decoded into steps; left only by reset
module quad_speed_meter #(
  parameter int WINDOW_CYCLES = 500000,
  parameter int FILT_LEN      = 4,
  parameter int DIR_INVERT    = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               clear,
  output logic signed [31:0] position,
  output logic signed [31:0] speed,
  output logic               speed_valid,
  output logic               enc_err
);

  localparam int WIN_W     = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int FILT_W    = $clog2(FILT_LEN + 1);
  // Long enough for the pins to cross the synchroniser before RUN starts,
  // so a pin that is already high at release never looks like an edge.
  localparam int INIT_LAST = FILT_LEN + 1;
  localparam int INIT_W    = $clog2(INIT_LAST + 1);

  localparam logic signed [32:0] SAT_POS = 33'sd2147483647;
  localparam logic signed [32:0] SAT_NEG = -33'sd2147483647;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state;
  logic [INIT_W-1:0]   init_cnt;
  logic                a_s1, a_s2, b_s1, b_s2;
  logic                a_filt, b_filt;
  logic [FILT_W-1:0]   a_cnt, b_cnt;
  logic [1:0]          prev_ab;
  logic [WIN_W-1:0]    win_cnt;
  logic signed [31:0]  acc;

  logic [1:0]          phase_diff;
  logic                step_up, step_dn, illegal;
  logic signed [32:0]  step;
  logic signed [32:0]  acc_sum;
  logic signed [31:0]  acc_next;
  logic                tc;

  // Position of an {A,B} pair along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  always_comb begin
    phase_diff = gray_idx({a_filt, b_filt}) - gray_idx(prev_ab);
    step_up    = 1'b0;
    step_dn    = 1'b0;
    illegal    = 1'b0;
    if (state == ST_RUN) begin
      illegal = (phase_diff == 2'd2);
      if (DIR_INVERT != 0) begin
        step_up = (phase_diff == 2'd3);
        step_dn = (phase_diff == 2'd1);
      end else begin
        step_up = (phase_diff == 2'd1);
        step_dn = (phase_diff == 2'd3);
      end
    end
    step = 33'sd0;
    if (step_up)      step = 33'sd1;
    else if (step_dn) step = -33'sd1;
    acc_sum = {acc[31], acc} + step;
    if (acc_sum > SAT_POS)      acc_next = SAT_POS[31:0];
    else if (acc_sum < SAT_NEG) acc_next = SAT_NEG[31:0];
    else                        acc_next = acc_sum[31:0];
    tc = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      init_cnt    <= '0;
      a_s1        <= 1'b0;
      a_s2        <= 1'b0;
      b_s1        <= 1'b0;
      b_s2        <= 1'b0;
      a_filt      <= 1'b0;
      b_filt      <= 1'b0;
      a_cnt       <= '0;
      b_cnt       <= '0;
      prev_ab     <= 2'b00;
      win_cnt     <= '0;
      acc         <= '0;
      position    <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      enc_err     <= 1'b0;
    end else begin
      a_s1 <= enc_a;
      a_s2 <= a_s1;
      b_s1 <= enc_b;
      b_s2 <= b_s1;

      case (state)
        ST_INIT: begin
          a_filt  <= a_s2;
          b_filt  <= b_s2;
          prev_ab <= {a_s2, b_s2};
          a_cnt   <= '0;
          b_cnt   <= '0;
          if (init_cnt == INIT_W'(INIT_LAST)) state <= ST_RUN;
          else                                init_cnt <= init_cnt + INIT_W'(1);
        end
        default: begin
          prev_ab <= {a_filt, b_filt};
          if (a_s2 == a_filt) begin
            a_cnt <= '0;
          end else if (a_cnt == FILT_W'(FILT_LEN - 1)) begin
            a_filt <= a_s2;
            a_cnt  <= '0;
          end else begin
            a_cnt <= a_cnt + FILT_W'(1);
          end
          if (b_s2 == b_filt) begin
            b_cnt <= '0;
          end else if (b_cnt == FILT_W'(FILT_LEN - 1)) begin
            b_filt <= b_s2;
            b_cnt  <= '0;
          end else begin
            b_cnt <= b_cnt + FILT_W'(1);
          end
        end
      endcase

      speed_valid <= 1'b0;
      if (clear) begin
        // Any step decoded this cycle is dropped along with the window.
        position <= '0;
        enc_err  <= 1'b0;
        acc      <= '0;
        win_cnt  <= '0;
      end else begin
        position <= position + step[31:0];
        if (illegal) enc_err <= 1'b1;
        if (tc) begin
          speed       <= acc_next;
          acc         <= '0;
          win_cnt     <= '0;
          speed_valid <= 1'b1;
        end else begin
          acc     <= acc_next;
          win_cnt <= win_cnt + WIN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_speed_meter.sv
module tb_quad_speed_meter;

  localparam int WIN = 1000;
  localparam int FL  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;
  logic clear = 1'b0;
  logic signed [31:0] pos0, spd0, pos1, spd1;
  logic sv0, sv1, err0, err1;

  always #5 clk = ~clk;

  quad_speed_meter #(.WINDOW_CYCLES(WIN), .FILT_LEN(FL), .DIR_INVERT(0)) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .position(pos0), .speed(spd0), .speed_valid(sv0), .enc_err(err0));

  quad_speed_meter #(.WINDOW_CYCLES(WIN), .FILT_LEN(FL), .DIR_INVERT(1)) dut_inv (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .position(pos1), .speed(spd1), .speed_valid(sv1), .enc_err(err1));

  int compared = 0;
  int mismatched = 0;

  // Reference model: physical wheel phase on the forward cycle, net counts.
  logic [1:0] gray [4];
  int     m_idx;
  logic [1:0] m_ab;
  int     m_pos;
  int     m_win;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One physical quadrature edge: dir=+1 forward, -1 reverse.
  task automatic move(input int dir, input int hold);
    m_idx = (m_idx + dir + 4) % 4;
    m_ab  = gray[m_idx];
    @(negedge clk);
    enc_a = m_ab[1];
    enc_b = m_ab[0];
    m_pos += dir;
    m_win += dir;
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    reset_n = 1'b0;
    enc_a = a;
    enc_b = b;
    clear = 1'b0;
    idle(3);
    reset_n = 1'b1;
    m_ab = {a, b};
    for (int i = 0; i < 4; i++) if (gray[i] == m_ab) m_idx = i;
    m_pos = 0;
    m_win = 0;
    idle(20);
  endtask

  // Returns the cycle stamp of the next strobe, or -1 after the budget.
  task automatic wait_strobe(output longint stamp);
    stamp = -1;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (sv0) begin
        stamp = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    #1;
    compared++;
    if ({pos0, spd0, sv0, err0} !== 66'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got pos=%0d spd=%0d sv=%0b err=%0b, want all 0", pos0, spd0, sv0, err0);
    end
    do_reset(1'b0, 1'b0);
    compared++;
    if (pos0 !== 32'sd0 || err0 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_settle: got pos=%0d err=%0b, want 0 0", pos0, err0);
    end
  endtask

  task automatic test_forward;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) move(1, 10);
    idle(10);
    compared++;
    if (pos0 !== 32'sd32 || pos0 !== m_pos) begin
      mismatched++;
      $display("FAIL fwd_pos: got %0d want %0d", pos0, m_pos);
    end
    compared++;
    if (pos1 !== -32'sd32) begin
      mismatched++;
      $display("FAIL fwd_pos_inv: got %0d want -32", pos1);
    end
    compared++;
    if (err0 !== 1'b0) begin
      mismatched++;
      $display("FAIL fwd_err: got %0b want 0", err0);
    end
  endtask

  task automatic test_reverse;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) move(-1, 10);
    idle(10);
    compared++;
    if (pos0 !== -32'sd32 || pos0 !== m_pos) begin
      mismatched++;
      $display("FAIL rev_pos: got %0d want %0d", pos0, m_pos);
    end
    compared++;
    if (pos1 !== 32'sd32) begin
      mismatched++;
      $display("FAIL rev_pos_inv: got %0d want 32", pos1);
    end
  endtask

  task automatic test_random_walk;
    for (int i = 0; i < 60; i++)
      move(($urandom_range(0, 1) == 0) ? -1 : 1, $urandom_range(6, 14));
    idle(10);
    compared++;
    if (pos0 !== m_pos || pos1 !== -m_pos) begin
      mismatched++;
      $display("FAIL walk_pos: got %0d/%0d want %0d/%0d", pos0, pos1, m_pos, -m_pos);
    end
    compared++;
    if (err0 !== 1'b0 || err1 !== 1'b0) begin
      mismatched++;
      $display("FAIL walk_err: got %0b/%0b want 0", err0, err1);
    end
  endtask

  task automatic test_window;
    longint s_prev, s_now;
    int k;
    wait_strobe(s_prev);
    compared++;
    if (s_prev < 0) begin
      mismatched++;
      $display("FAIL win_first_strobe: got timeout want strobe");
    end
    idle(1);
    compared++;
    if (sv0 !== 1'b0) begin
      mismatched++;
      $display("FAIL win_strobe_width: got sv=1 on second cycle want 0");
    end
    m_win = 0;
    for (int i = 0; i < 50; i++) move(1, 15);
    wait_strobe(s_now);
    compared++;
    if (s_now - s_prev != 1000) begin
      mismatched++;
      $display("FAIL win_spacing_a: got %0d want 1000", s_now - s_prev);
    end
    compared++;
    if (spd0 !== 32'sd50 || spd1 !== -32'sd50) begin
      mismatched++;
      $display("FAIL win_speed_50: got %0d/%0d want 50/-50", spd0, spd1);
    end
    s_prev = s_now;
    m_win = 0;
    k = $urandom_range(10, 50);
    for (int i = 0; i < k; i++) move(($urandom_range(0, 2) == 0) ? -1 : 1, 15);
    idle(300);
    compared++;
    if (spd0 !== 32'sd50) begin
      mismatched++;
      $display("FAIL win_speed_hold: got %0d want 50", spd0);
    end
    wait_strobe(s_now);
    compared++;
    if (spd0 !== m_win || spd1 !== -m_win || s_now - s_prev != 1000) begin
      mismatched++;
      $display("FAIL win_speed_rand: got %0d/%0d gap %0d want %0d/%0d gap 1000",
               spd0, spd1, s_now - s_prev, m_win, -m_win);
    end
    s_prev = s_now;
    m_win = 0;
    wait_strobe(s_now);
    compared++;
    if (spd0 !== 32'sd0 || s_now - s_prev != 1000) begin
      mismatched++;
      $display("FAIL win_speed_idle: got %0d gap %0d want 0 gap 1000", spd0, s_now - s_prev);
    end
  endtask

  task automatic test_filter;
    int p0, dir, len;
    logic [1:0] nab;
    p0 = m_pos;
    for (int g = 0; g < 6; g++) begin
      len = $urandom_range(1, FL - 1);
      @(negedge clk);
      enc_a = ~m_ab[1];
      repeat (len) @(negedge clk);
      enc_a = m_ab[1];
      idle($urandom_range(5, 20));
    end
    idle(10);
    compared++;
    if (pos0 !== p0 || err0 !== 1'b0) begin
      mismatched++;
      $display("FAIL filt_glitch: got pos=%0d err=%0b want %0d 0", pos0, err0, p0);
    end
    nab = {~m_ab[1], m_ab[0]};
    dir = 0;
    for (int i = 0; i < 4; i++) if (gray[i] == nab) dir = ((i - m_idx + 4) % 4 == 1) ? 1 : -1;
    @(negedge clk);
    enc_a = nab[1];
    repeat (4) @(negedge clk);
    enc_a = m_ab[1];
    repeat (2) @(negedge clk);
    compared++;
    if (pos0 !== p0) begin
      mismatched++;
      $display("FAIL filt_latency_early: got %0d want %0d after 6 edges", pos0, p0);
    end
    @(negedge clk);
    compared++;
    if (pos0 !== p0 + dir) begin
      mismatched++;
      $display("FAIL filt_latency_7: got %0d want %0d after 7 edges", pos0, p0 + dir);
    end
    idle(12);
    compared++;
    if (pos0 !== p0 || err0 !== 1'b0) begin
      mismatched++;
      $display("FAIL filt_pulse_return: got %0d want %0d", pos0, p0);
    end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    m_idx = (m_idx + 2) % 4;
    m_ab = gray[m_idx];
    enc_a = m_ab[1];
    enc_b = m_ab[0];
    idle(12);
    compared++;
    if (err0 !== 1'b1 || err1 !== 1'b1 || pos0 !== m_pos) begin
      mismatched++;
      $display("FAIL illegal_flag: got err=%0b/%0b pos=%0d want 1/1 %0d", err0, err1, pos0, m_pos);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pos = 0;
    m_win = 0;
    compared++;
    if (err0 !== 1'b0 || pos0 !== 32'sd0 || pos1 !== 32'sd0) begin
      mismatched++;
      $display("FAIL illegal_clear: got err=%0b pos=%0d/%0d want 0 0/0", err0, pos0, pos1);
    end
  endtask

  task automatic test_clear_tc;
    longint s, s2;
    int k, old_spd;
    bit seen;
    wait_strobe(s);
    m_win = 0;
    k = $urandom_range(5, 30);
    for (int i = 0; i < k; i++) move(1, 12);
    wait_strobe(s);
    compared++;
    if (s < 0 || spd0 !== m_win) begin
      mismatched++;
      $display("FAIL ctc_pre_speed: got %0d (stamp %0d) want %0d", spd0, s, m_win);
    end
    old_spd = m_win;
    m_win = 0;
    k = $urandom_range(3, 10);
    for (int i = 0; i < k; i++) move(-1, 12);
    while (cyc < s + 999) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pos = 0;
    m_win = 0;
    seen = sv0;
    for (int i = 0; i < 990; i++) begin
      @(negedge clk);
      if (sv0) seen = 1'b1;
    end
    compared++;
    if (seen) begin
      mismatched++;
      $display("FAIL ctc_no_strobe: got strobe want none");
    end
    compared++;
    if (spd0 !== old_spd || spd1 !== -old_spd || pos0 !== 32'sd0) begin
      mismatched++;
      $display("FAIL ctc_speed_kept: got spd=%0d/%0d pos=%0d want %0d/%0d 0", spd0, spd1, pos0, old_spd, -old_spd);
    end
    wait_strobe(s2);
    compared++;
    if (s2 != s + 2000 || spd0 !== 32'sd0) begin
      mismatched++;
      $display("FAIL ctc_restart: got stamp %0d spd %0d want %0d 0", s2, spd0, s + 2000);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) move(1, 10);
    idle(3);
    #2;
    reset_n = 1'b0;
    #1;
    compared++;
    if ({pos0, spd0, sv0, err0, pos1, spd1, sv1, err1} !== 132'd0) begin
      mismatched++;
      $display("FAIL rst_mid_async: got pos=%0d spd=%0d sv=%0b err=%0b want 0", pos0, spd0, sv0, err0);
    end
    enc_a = 1'b1;
    enc_b = 1'b0;
    idle(3);
    reset_n = 1'b1;
    m_ab = 2'b10;
    m_idx = 3;
    m_pos = 0;
    m_win = 0;
    idle(20);
    compared++;
    if (pos0 !== 32'sd0 || err0 !== 1'b0 || pos1 !== 32'sd0) begin
      mismatched++;
      $display("FAIL rst_mid_pin_high: got pos=%0d err=%0b want 0 0", pos0, err0);
    end
    move(1, 10);
    idle(10);
    compared++;
    if (pos0 !== m_pos || pos1 !== -m_pos || err0 !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_resume: got %0d/%0d want %0d/%0d", pos0, pos1, m_pos, -m_pos);
    end
  endtask

  initial begin
    gray[0] = 2'b00;
    gray[1] = 2'b01;
    gray[2] = 2'b11;
    gray[3] = 2'b10;
    m_idx = 0;
    m_ab = 2'b00;
    m_pos = 0;
    m_win = 0;
    test_reset();
    test_forward();
    test_reverse();
    test_random_walk();
    test_window();
    test_filter();
    test_illegal();
    test_clear_tc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
